// File: rtl/trees_spawner_if.sv
// -----------------------------------------------------------------------------
// trees_spawner_if
//
// Purpose : bundles the frame/control inputs and the per-slot tree outputs of
//           trees_spawner into one interface. The game/test side uses the
//           master modport and the spawner uses the slave modport.
//
// Signals :
//   startOfFrame     master->slave  one-cycle pulse, once per video frame
//   enable           master->slave  game running; 0 freezes movement/spawning
//   collisionTree    master->slave  per-slot hit, retires that slot
//   treesCoordinates slave->master  [i][0]=X, [i][1]=Y (top-left, signed 11b)
//   isActive         slave->master  slot i currently on the playfield
//   deploy_tree      slave->master  one-cycle pulse when slot i is spawned
//   droppedSpawn     slave->master  one-cycle pulse: spawn due, no free slot
//   currentSpeed     slave->master  scroll speed in effect (pixels/frame)
// -----------------------------------------------------------------------------
interface trees_spawner_if #(
    parameter int NUMBER_OF_TREES = 16
);
    logic                                           startOfFrame;
    logic                                           enable;
    logic        [NUMBER_OF_TREES-1:0]              collisionTree;
    logic signed [NUMBER_OF_TREES-1:0][1:0][10:0]   treesCoordinates;
    logic        [NUMBER_OF_TREES-1:0]              isActive;
    logic        [NUMBER_OF_TREES-1:0]              deploy_tree;
    logic                                           droppedSpawn;
    logic        [3:0]                              currentSpeed;

    modport master (
        output startOfFrame,
        output enable,
        output collisionTree,
        input  treesCoordinates,
        input  isActive,
        input  deploy_tree,
        input  droppedSpawn,
        input  currentSpeed
    );

    modport slave (
        input  startOfFrame,
        input  enable,
        input  collisionTree,
        output treesCoordinates,
        output isActive,
        output deploy_tree,
        output droppedSpawn,
        output currentSpeed
    );
endinterface : trees_spawner_if

// File: rtl/trees_spawner.sv
// -----------------------------------------------------------------------------
// trees_spawner
//
// Purpose : keeps a pool of NUMBER_OF_TREES tree slots. Once per frame every
//           active tree scrolls down by the current speed; trees that leave
//           the bottom edge or are hit are retired; every SPAWN_INTERVAL
//           frames the lowest free slot is re-deployed above the top edge at
//           a pseudo-random X taken from a 16-bit Galois LFSR.
//
// Ports   :
//   clk     in   system clock
//   resetN  in   synchronous, active-HIGH reset (1 = reset); legacy name
//   bus     slave modport of trees_spawner_if (frame/enable/collision in,
//           coordinates/active/deploy/dropped/speed out)
//
// Sequence: IDLE --(registered startOfFrame & enable)--> MOVE --> SPAWN --> IDLE
//           startOfFrame is registered once on entry, so moved coordinates
//           appear two edges after the pulse is sampled and a spawned slot
//           appears three edges after it.
//
// Optional: define TREES_SPEEDUP_EN to add a frame counter that raises the
//           scroll speed by 1 every 600 frames, saturating at 8. Without it
//           the speed is the constant SPEED.
// -----------------------------------------------------------------------------
module trees_spawner #(
    parameter int          NUMBER_OF_TREES = 16,
    parameter int          SCREEN_WIDTH    = 640,
    parameter int          SCREEN_HEIGHT   = 480,
    parameter int          TREE_WIDTH      = 32,
    parameter int          TREE_HEIGHT     = 64,
    parameter int          SPAWN_INTERVAL  = 45,
    parameter int          SPEED           = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic           clk,
    input  logic           resetN,
    trees_spawner_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 IDX_W     = (NUMBER_OF_TREES > 1) ? $clog2(NUMBER_OF_TREES) : 1;
    localparam logic        [10:0] X_SPAN    = 11'(SCREEN_WIDTH - TREE_WIDTH);
    localparam logic signed [10:0] Y_LIMIT   = 11'(SCREEN_HEIGHT);
    localparam logic        [10:0] SPAWN_Y   = 11'(-TREE_HEIGHT);
    localparam logic        [7:0]  TIMER_RLD = 8'(SPAWN_INTERVAL);
    localparam logic        [15:0] LFSR_TAPS = 16'hB400;  // taps 16,14,13,11

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SPAWN = 2'd2
    } state_t;

    typedef logic [NUMBER_OF_TREES-1:0][1:0][10:0] coords_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                     state_q,   state_d;
    logic                       sof_q;
    logic [15:0]                lfsr_q,    lfsr_d;
    logic [7:0]                 timer_q,   timer_d;
    logic [NUMBER_OF_TREES-1:0] active_q,  active_d;
    coords_t                    coords_q,  coords_d;
    logic [NUMBER_OF_TREES-1:0] deploy_q,  deploy_d;
    logic                       dropped_q, dropped_d;
    logic [3:0]                 speed_w;

`ifdef TREES_SPEEDUP_EN
    localparam logic [9:0] FRAMES_PER_STEP = 10'd600;
    localparam logic [3:0] SPEED_MAX       = 4'd8;

    logic [3:0] speed_q, speed_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;

    assign speed_w = speed_q;
`else
    assign speed_w = 4'(SPEED);
`endif

    // ------------------------------------------------------------------------
    // LFSR and spawn position
    // ------------------------------------------------------------------------
    // Right-shifting Galois form: the bit falling out of the bottom feeds the
    // tap positions. It free-runs every clock, independent of enable.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    logic [10:0] raw_x;
    logic [10:0] spawn_x;

    // A 10-bit value is below 2*X_SPAN, so one conditional subtract folds
    // it into 0..X_SPAN-1 without a divider.
    assign raw_x   = {1'b0, lfsr_q[9:0]};
    assign spawn_x = (raw_x >= X_SPAN) ? (raw_x - X_SPAN) : raw_x;

    // ------------------------------------------------------------------------
    // Lowest-index free slot, taken from the registered flags so that slots
    // retired in the preceding MOVE (or by an earlier hit) are eligible.
    // ------------------------------------------------------------------------
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        // Scan downwards so the last hit, i.e. the lowest index, wins.
        for (int i = NUMBER_OF_TREES - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    logic signed [10:0] y_new;

    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that paths which do not assign it cannot infer a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        coords_d  = coords_q;
        deploy_d  = '0;
        dropped_d = 1'b0;
        y_new     = '0;
        // Hits retire a slot in any state; a hit on an inactive slot is a
        // no-op because its flag is already clear.
        active_d  = active_q & ~bus.collisionTree;
`ifdef TREES_SPEEDUP_EN
        speed_d     = speed_q;
        frame_cnt_d = frame_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (sof_q && bus.enable) begin
                    state_d = MOVE;
                end
            end

            MOVE: begin
                state_d = SPAWN;
                timer_d = timer_q - 8'd1;
                for (int i = 0; i < NUMBER_OF_TREES; i++) begin
                    // A slot hit in this same cycle is not advanced.
                    if (active_q[i] && !bus.collisionTree[i]) begin
                        y_new          = $signed(coords_q[i][1]) + $signed({7'b0, speed_w});
                        coords_d[i][1] = y_new;
                        // The off-screen Y is kept; only the flag is cleared.
                        if (y_new >= Y_LIMIT) begin
                            active_d[i] = 1'b0;
                        end
                    end
                end
`ifdef TREES_SPEEDUP_EN
                if (frame_cnt_q == FRAMES_PER_STEP - 10'd1) begin
                    frame_cnt_d = '0;
                    if (speed_q < SPEED_MAX) begin
                        speed_d = speed_q + 4'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 10'd1;
                end
`endif
            end

            SPAWN: begin
                state_d = IDLE;
                if (timer_q == 8'd0) begin
                    // The timer reloads whether or not a slot was available.
                    timer_d = TIMER_RLD;
                    if (free_found) begin
                        coords_d[free_idx][0] = spawn_x;
                        coords_d[free_idx][1] = SPAWN_Y;
                        active_d[free_idx]    = 1'b1;
                        deploy_d[free_idx]    = 1'b1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q   <= IDLE;
            sof_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            timer_q   <= TIMER_RLD;
            active_q  <= '0;
            // NOTE: the coordinate table is a bank of flops read directly by
            // the sprite drawers, not a RAM, so it is cleared with the rest.
            coords_q  <= '0;
            deploy_q  <= '0;
            dropped_q <= 1'b0;
`ifdef TREES_SPEEDUP_EN
            speed_q     <= 4'(SPEED);
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sof_q     <= bus.startOfFrame;
            lfsr_q    <= lfsr_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
            coords_q  <= coords_d;
            deploy_q  <= deploy_d;
            dropped_q <= dropped_d;
`ifdef TREES_SPEEDUP_EN
            speed_q     <= speed_d;
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign bus.treesCoordinates = coords_q;
    assign bus.isActive         = active_q;
    assign bus.deploy_tree      = deploy_q;
    assign bus.droppedSpawn     = dropped_q;
    assign bus.currentSpeed     = speed_w;

endmodule : trees_spawner

// File: doc/trees_spawner.md
Name: trees_spawner

Overview:
- Manages a pool of NUMBER_OF_TREES tree slots that feed the tree object drawers and the tree priority mux.
- Once per video frame, every active tree scrolls down the screen by the current speed.
- Trees that leave the bottom of the screen, or are hit, are retired.
- A free slot is periodically re-deployed at a pseudo-random X position above the top edge.
- Outputs are per-slot coordinates, per-slot active flags and per-slot deploy pulses.

Parameters:
NUMBER_OF_TREES, 16, number of tree slots
SCREEN_WIDTH, 640, visible width in pixels
SCREEN_HEIGHT, 480, visible height in pixels
TREE_WIDTH, 32, sprite width; X range is 0..SCREEN_WIDTH-TREE_WIDTH-1
TREE_HEIGHT, 64, sprite height; spawn Y is -TREE_HEIGHT
SPAWN_INTERVAL, 45, frames between spawn attempts (1..255)
SPEED, 2, initial scroll speed in pixels/frame (1..15)
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
resetN  in  1  synchronous, active-high reset; 1 = reset; name kept for codebase consistency
startOfFrame  in  1  one-cycle pulse, once per frame
enable  in  1  game running; 0 freezes movement and spawning
collisionTree  in  [NUMBER_OF_TREES-1:0]  per-slot hit; retires that slot
treesCoordinates  out  signed [NUMBER_OF_TREES-1:0][1:0][10:0]  [i][0]=X, [i][1]=Y (top-left)
isActive  out  [NUMBER_OF_TREES-1:0]  slot i currently on the playfield
deploy_tree  out  [NUMBER_OF_TREES-1:0]  one-cycle pulse when slot i is spawned
droppedSpawn  out  1  one-cycle pulse when a spawn is due but no slot is free
currentSpeed  out  4  scroll speed in effect

Behaviour:
Reset (resetN=1 at a clock edge):
- isActive=0, all coordinates=0, deploy_tree=0, droppedSpawn=0.
- currentSpeed=SPEED, spawn timer=SPAWN_INTERVAL, lfsr=LFSR_SEED, state=IDLE.
- Reset overrides everything, including mid-MOVE/SPAWN; no partial update survives.

LFSR:
- 16-bit Galois, taps 16,14,13,11; advances every clock including while enable=0.
- Spawn X = lfsr[9:0]; if X >= SCREEN_WIDTH-TREE_WIDTH, X = lfsr[9:0] - (SCREEN_WIDTH-TREE_WIDTH).
- Result is always in 0..607 for default parameters.

FSM, states IDLE, MOVE, SPAWN:
- IDLE: startOfFrame & enable -> MOVE. Otherwise stay.
- MOVE, 1 cycle, then -> SPAWN:
  - Every active slot: Y <= Y + currentSpeed, 11-bit signed arithmetic.
  - If the new Y >= SCREEN_HEIGHT, clear isActive[i]; coordinates keep the last value.
  - Spawn timer decrements.
- SPAWN, 1 cycle, then -> IDLE. Acts only if the timer reached 0:
  - Reload timer to SPAWN_INTERVAL.
  - Pick the lowest-index slot with isActive=0.
  - Load it with X from the LFSR, Y=-TREE_HEIGHT; set isActive; pulse deploy_tree[i] in the same registered update.
  - If no slot is free: droppedSpawn pulses and the timer still reloads.
- startOfFrame arriving while in MOVE or SPAWN is ignored.

Latency:
- startOfFrame sampled at edge t.
- Moved coordinates are visible after edge t+2.
- A spawned slot's isActive and deploy_tree are visible after edge t+3; deploy_tree stays high exactly 1 cycle.

Collision:
- collisionTree[i]=1 clears isActive[i] at the next edge, in any state.
- This takes priority over the MOVE update of that slot.
- A hit on an inactive slot is ignored.
- A slot retired in MOVE or by collision is eligible in the following SPAWN cycle.

enable=0:
- FSM does not leave IDLE; the timer and coordinates hold.
- Collisions are still processed.
- Dropping enable mid-MOVE/SPAWN lets the sequence finish.

Optional Feature:
Macro TREES_SPEEDUP_EN.
- Defined: a 10-bit frame counter counts MOVE cycles. Every 600 frames currentSpeed increments by 1, saturating at 8, and the counter wraps to 0. Reset restores SPEED and clears the counter.
- Undefined: no counter; currentSpeed is constant SPEED.

Test Plan:
- Reset, then enable=1 with 45 startOfFrame pulses -> after the 45th: slot 0 isActive=1, Y=-64, X in 0..607, deploy_tree=16'h0001 for 1 cycle; slots 1..15 inactive.
- Slot 0 active at Y=-64, 10 more frames at SPEED=2 -> Y=-44; all other coordinates unchanged.
- Tree at Y=478 with a frame pulse -> computed Y=480, isActive[i]=0 after MOVE; it is reused at the next spawn, as the lowest free index.
- All 16 slots active and spawn due -> droppedSpawn pulses once, no deploy_tree bit set, timer reloads to 45.
- collisionTree=16'h0004 asserted in the same cycle as MOVE -> isActive[2]=0, slot 2's Y not advanced; same pulse on an inactive slot -> no change.
- resetN=1 held for 1 cycle during the SPAWN state -> all outputs at reset values next cycle, no deploy pulse. With TREES_SPEEDUP_EN: 600 frames -> currentSpeed=3; 4200 frames -> saturates at 8.
